// File: rtl/crc_32_4parallel_checker.sv
// Receive-side CRC-32 checker for the 4-lane x 48-bit packet datapath (reflected poly 0xEDB88320, lane 0 first).
// Optional statistics counters are built only when CRC_CHK_STATS_EN is defined.
module crc_32_4parallel_checker #(
    parameter int          FAST        = 0,
    parameter logic [31:0] CRC_INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOR_OUT = 32'hFFFFFFFF,
    parameter int          MAX_WORDS   = 256,
    parameter int          CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VLD,
    input  logic             SOP,
    input  logic             EOP,
    input  logic [3:0]       VALID,
    input  logic [191:0]     DATA,
    input  logic [31:0]      CRC_RX,
    output logic             DONE,
    output logic             CRC_OK,
    output logic             CRC_ERR,
    output logic [31:0]      CRC_CALC,
    output logic             PROTO_ERR,
    output logic [CNT_W-1:0] PKT_CNT,
    output logic [CNT_W-1:0] ERR_CNT
);

    localparam logic [31:0] POLY = 32'hEDB88320;
    localparam int          WC_W = $clog2(MAX_WORDS + 6);
    localparam logic [WC_W-1:0] WC_SAT = WC_W'(MAX_WORDS + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WORDS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     crc_acc_q, crc_acc_d;
    logic [WC_W-1:0] word_cnt_q, word_cnt_d;
    logic            done_d, ok_d, err_d, proto_d;
    logic [31:0]     calc_d;

    logic            accept, finish;
    logic [2:0]      lane_cnt;
    logic [31:0]     core_in, core_out, final_crc;
    logic [WC_W-1:0] cnt_base, cnt_sum, cnt_next;

    function automatic logic [31:0] crc_word(input logic [31:0] crc_in, input logic [47:0] word);
        logic [31:0] c;
        c = crc_in;
        for (int unsigned b = 0; b < 48; b++) begin
            c[0] = c[0] ^ word[b];
            c    = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] crc_generic(input logic [31:0] crc_in, input logic [3:0] vld,
                                                input logic [191:0] dat);
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 4; i++) begin
            if (vld[i]) c = crc_word(c, dat[i*48 +: 48]);
        end
        return c;
    endfunction

    always_comb begin
        lane_cnt = {2'b00, VALID[0]} + {2'b00, VALID[1]} + {2'b00, VALID[2]} + {2'b00, VALID[3]};
    end

    // Stand-in for the CRC_32_4PARALLEL core: FAST compacts valid lanes and picks a fixed-width chain by count.
    if (FAST != 0) begin : g_fast
        logic [47:0] lane_words [4];
        logic [2:0]  slot;
        logic [31:0] c1, c2, c3, c4;

        always_comb begin
            for (int unsigned k = 0; k < 4; k++) lane_words[k] = '0;
            slot = '0;
            for (int unsigned i = 0; i < 4; i++) begin
                if (VALID[i]) begin
                    lane_words[slot[1:0]] = DATA[i*48 +: 48];
                    slot = slot + 3'd1;
                end
            end
            c1 = crc_word(core_in, lane_words[0]);
            c2 = crc_word(c1, lane_words[1]);
            c3 = crc_word(c2, lane_words[2]);
            c4 = crc_word(c3, lane_words[3]);
            case (lane_cnt)
                3'd1:    core_out = c1;
                3'd2:    core_out = c2;
                3'd3:    core_out = c3;
                3'd4:    core_out = c4;
                default: core_out = core_in;
            endcase
        end
    end else begin : g_generic
        always_comb core_out = crc_generic(core_in, VALID, DATA);
    end

    always_comb begin
        accept    = IN_VLD & (SOP | (state_q == ACTIVE));
        finish    = accept & EOP;
        core_in   = SOP ? CRC_INIT : crc_acc_q;
        final_crc = core_out ^ CRC_XOR_OUT;
        cnt_base  = SOP ? '0 : word_cnt_q;
        cnt_sum   = cnt_base + WC_W'(lane_cnt);
        cnt_next  = (cnt_sum > WC_SAT) ? WC_SAT : cnt_sum;

        state_d   = state_q;
        crc_acc_d = crc_acc_q;
        word_cnt_d = word_cnt_q;
        done_d    = 1'b0;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        calc_d    = CRC_CALC;
        // SOP in ACTIVE abandons the open packet; SOP-less beats in IDLE are dropped.
        proto_d   = IN_VLD & ((state_q == IDLE) ? ~SOP : SOP);

        if (accept) begin
            crc_acc_d  = core_out;
            word_cnt_d = cnt_next;
            state_d    = EOP ? IDLE : ACTIVE;
        end
        if (finish) begin
            done_d = 1'b1;
            calc_d = final_crc;
            ok_d   = (final_crc == CRC_RX) && (cnt_next <= WC_MAX);
            err_d  = ~ok_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            crc_acc_q  <= CRC_INIT;
            word_cnt_q <= '0;
            DONE       <= 1'b0;
            CRC_OK     <= 1'b0;
            CRC_ERR    <= 1'b0;
            CRC_CALC   <= '0;
            PROTO_ERR  <= 1'b0;
        end else begin
            crc_acc_q  <= crc_acc_d;
            word_cnt_q <= word_cnt_d;
            DONE       <= done_d;
            CRC_OK     <= ok_d;
            CRC_ERR    <= err_d;
            CRC_CALC   <= calc_d;
            PROTO_ERR  <= proto_d;
        end
    end

`ifdef CRC_CHK_STATS_EN
    logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (finish) begin
            if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 1'b1;
            if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign PKT_CNT = pkt_cnt_q;
    assign ERR_CNT = err_cnt_q;
`else
    assign PKT_CNT = '0;
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_crc_32_4parallel_checker.sv
// Self-checking bench for crc_32_4parallel_checker: byte-level CRC-32 packet model plus directed packets.
module tb_crc_32_4parallel_checker;

    localparam int MAXW = 8;
    localparam int CW   = 4;
`ifdef CRC_CHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [7:0]  bytes_t [$];
    typedef logic [47:0] words_t [$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0, sop = 1'b0, eop = 1'b0;
    logic [3:0]    valid = '0;
    logic [191:0]  data = '0;
    logic [31:0]   crc_rx = '0;
    logic          done, crc_ok, crc_err, proto_err;
    logic [31:0]   crc_calc;
    logic [CW-1:0] pkt_cnt, err_cnt;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int proto_seen = 0;

    always #5 clk = ~clk;

    crc_32_4parallel_checker #(.FAST(0), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .CLK(clk), .RST(rst), .IN_VLD(in_vld), .SOP(sop), .EOP(eop), .VALID(valid),
        .DATA(data), .CRC_RX(crc_rx), .DONE(done), .CRC_OK(crc_ok), .CRC_ERR(crc_err),
        .CRC_CALC(crc_calc), .PROTO_ERR(proto_err), .PKT_CNT(pkt_cnt), .ERR_CNT(err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard CRC-32 (as used by zip/ethernet) over a byte stream.
    function automatic logic [31:0] crc32_bytes(input bytes_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[n]) begin
            c = c ^ {24'd0, b[n]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Each 48-bit word is transmitted as six bytes, least significant byte first.
    function automatic bytes_t words_to_bytes(input words_t w);
        bytes_t b;
        foreach (w[n]) for (int k = 0; k < 6; k++) b.push_back(w[n][k*8 +: 8]);
        return b;
    endfunction

    function automatic logic [191:0] mk(input int s);
        logic [191:0] d;
        for (int i = 0; i < 4; i++)
            d[i*48 +: 48] = {16'(32'h1357 + 32'(s*4 + i)), 32'h9E3779B9 * 32'(s*4 + i + 1)};
        return d;
    endfunction

    // Packet-level reference model and per-cycle compare.
    words_t        m_words;
    bit            m_open = 1'b0;
    logic          e_done = 1'b0, e_ok = 1'b0, e_err = 1'b0, e_proto = 1'b0;
    logic [31:0]   e_calc = '0;
    logic [CW-1:0] e_pkt = '0, e_errc = '0;

    always @(posedge clk) begin
        logic [31:0] c;
        e_done = 1'b0; e_ok = 1'b0; e_err = 1'b0; e_proto = 1'b0;
        if (rst) begin
            m_open = 1'b0; m_words.delete();
            e_calc = '0; e_pkt = '0; e_errc = '0;
        end else if (in_vld) begin
            if (sop) begin
                e_proto = m_open;
                m_words.delete();
                m_open = 1'b1;
            end else if (!m_open) begin
                e_proto = 1'b1;
            end
            if (m_open) begin
                for (int i = 0; i < 4; i++) if (valid[i]) m_words.push_back(data[i*48 +: 48]);
                if (eop) begin
                    c      = crc32_bytes(words_to_bytes(m_words));
                    e_calc = c;
                    e_ok   = (c == crc_rx) && (m_words.size() <= MAXW);
                    e_err  = !e_ok;
                    e_done = 1'b1;
                    if (STATS && e_pkt != '1) e_pkt = e_pkt + 1'b1;
                    if (STATS && e_err && e_errc != '1) e_errc = e_errc + 1'b1;
                    m_open = 1'b0;
                end
            end
        end
        #1;
        chk("cyc_done", 32'(done), 32'(e_done));
        chk("cyc_ok", 32'(crc_ok), 32'(e_ok));
        chk("cyc_err", 32'(crc_err), 32'(e_err));
        chk("cyc_proto", 32'(proto_err), 32'(e_proto));
        chk("cyc_calc", crc_calc, e_calc);
        chk("cyc_pkt_cnt", 32'(pkt_cnt), 32'(e_pkt));
        chk("cyc_err_cnt", 32'(err_cnt), 32'(e_errc));
        if (done === 1'b1) done_seen++;
        if (proto_err === 1'b1) proto_seen++;
    end

    logic [3:0]   bv [$];
    logic [191:0] bd [$];

    task automatic idle();
        in_vld = 1'b0; sop = 1'b0; eop = 1'b0; valid = '0;
    endtask

    task automatic send_pkt(input logic [31:0] flip, input bit gap, output logic [31:0] gold);
        words_t w;
        int last;
        last = bv.size() - 1;
        foreach (bv[b]) for (int i = 0; i < 4; i++) if (bv[b][i]) w.push_back(bd[b][i*48 +: 48]);
        gold = crc32_bytes(words_to_bytes(w));
        for (int b = 0; b <= last; b++) begin
            @(negedge clk);
            in_vld = 1'b1; sop = (b == 0); eop = (b == last);
            valid = bv[b]; data = bd[b];
            crc_rx = (b == last) ? (gold ^ flip) : 32'hDEADBEEF;
            if (gap && b != last) begin
                @(negedge clk);
                idle();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g, g2;
        bytes_t asc;
        bytes_t none;
        int d0, p0;

        asc = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_123456789", crc32_bytes(asc), 32'hCBF43926);
        asc = '{8'h61};
        chk("model_a", crc32_bytes(asc), 32'hE8B7BE43);
        chk("model_empty", crc32_bytes(none), 32'h00000000);

        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_calc", crc_calc, 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst = 1'b0;

        // single-beat packet
        bv = '{4'hF}; bd = '{mk(1)};
        send_pkt(32'd0, 1'b0, g);
        @(negedge clk);
        chk("sb_done", 32'(done), 32'd1);
        chk("sb_ok", 32'(crc_ok), 32'd1);
        chk("sb_calc", crc_calc, g);
        chk("sb_pkt_cnt", 32'(pkt_cnt), STATS ? 32'd1 : 32'd0);
        chk("sb_err_cnt", 32'(err_cnt), 32'd0);
        idle();

        // 3-beat with masks and idle gaps, wrong CRC
        bv = '{4'hF, 4'h5, 4'h1}; bd = '{mk(2), mk(3), mk(4)};
        send_pkt(32'h1, 1'b1, g);
        @(negedge clk);
        chk("m3_err", 32'(crc_err), 32'd1);
        chk("m3_ok", 32'(crc_ok), 32'd0);
        chk("m3_calc", crc_calc, g);
        chk("m3_err_cnt", 32'(err_cnt), STATS ? 32'd1 : 32'd0);
        idle();
        @(negedge clk);
        chk("m3_calc_held", crc_calc, g);

        // back-to-back
        d0 = done_seen;
        bv = '{4'hF, 4'h3}; bd = '{mk(5), mk(6)};
        send_pkt(32'd0, 1'b0, g);
        bv = '{4'hA}; bd = '{mk(7)};
        send_pkt(32'd0, 1'b0, g2);
        @(negedge clk);
        chk("b2b_ok", 32'(crc_ok), 32'd1);
        chk("b2b_calc", crc_calc, g2);
        idle();
        @(negedge clk);
        chk("b2b_dones", 32'(done_seen - d0), 32'd2);

        // beat without SOP in IDLE
        p0 = proto_seen; d0 = done_seen;
        @(negedge clk);
        in_vld = 1'b1; sop = 1'b0; eop = 1'b1; valid = 4'hF; data = mk(8);
        @(negedge clk);
        chk("idle_proto", 32'(proto_err), 32'd1);
        chk("idle_nodone", 32'(done), 32'd0);
        idle();
        @(negedge clk);
        chk("idle_proto_pulse", 32'(proto_err), 32'd0);

        // SOP mid-packet restarts
        @(negedge clk);
        in_vld = 1'b1; sop = 1'b1; eop = 1'b0; valid = 4'hF; data = mk(20);
        bv = '{4'h6, 4'hF}; bd = '{mk(21), mk(22)};
        send_pkt(32'd0, 1'b0, g);
        @(negedge clk);
        chk("restart_ok", 32'(crc_ok), 32'd1);
        chk("restart_calc", crc_calc, g);
        idle();
        @(negedge clk);
        chk("restart_dones", 32'(done_seen - d0), 32'd1);
        chk("restart_protos", 32'(proto_seen - p0), 32'd2);

        // length: 9 words fails, exactly 8 passes
        bv = '{4'hF, 4'hF, 4'h1}; bd = '{mk(30), mk(31), mk(32)};
        send_pkt(32'd0, 1'b0, g);
        @(negedge clk);
        chk("len9_err", 32'(crc_err), 32'd1);
        chk("len9_ok", 32'(crc_ok), 32'd0);
        chk("len9_calc", crc_calc, g);
        idle();
        bv = '{4'hF, 4'hF}; bd = '{mk(33), mk(34)};
        send_pkt(32'd0, 1'b0, g);
        @(negedge clk);
        chk("len8_ok", 32'(crc_ok), 32'd1);
        idle();

        // empty packet: CRC is seed XOR out
        bv = '{4'h0}; bd = '{mk(35)};
        send_pkt(32'd0, 1'b0, g);
        @(negedge clk);
        chk("empty_ok", 32'(crc_ok), 32'd1);
        chk("empty_calc", crc_calc, 32'h00000000);
        idle();

        // reset mid-packet
        @(negedge clk);
        in_vld = 1'b1; sop = 1'b1; eop = 1'b0; valid = 4'hF; data = mk(40);
        @(negedge clk);
        sop = 1'b0; data = mk(41);
        @(negedge clk);
        rst = 1'b1; idle();
        @(negedge clk);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_calc", crc_calc, 32'd0);
        chk("rstmid_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        in_vld = 1'b1; sop = 1'b0; eop = 1'b1; valid = 4'hF; data = mk(42);
        @(negedge clk);
        chk("rstmid_dropped", 32'(done), 32'd0);
        idle();
        bv = '{4'h9, 4'h2}; bd = '{mk(43), mk(44)};
        send_pkt(32'd0, 1'b0, g);
        @(negedge clk);
        chk("rstmid_next_ok", 32'(crc_ok), 32'd1);
        chk("rstmid_pkt_cnt", 32'(pkt_cnt), STATS ? 32'd1 : 32'd0);
        idle();

        // counter saturation
        for (int n = 0; n < 17; n++) begin
            bv = '{4'hF}; bd = '{mk(50 + n)};
            send_pkt(32'd0, 1'b0, g);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("sat_pkt_cnt", 32'(pkt_cnt), STATS ? 32'hF : 32'd0);
        chk("sat_err_cnt", 32'(err_cnt), 32'd0);
        bv = '{4'hC}; bd = '{mk(80)};
        send_pkt(32'h8000_0000, 1'b0, g);
        @(negedge clk);
        chk("sat_bad_err", 32'(crc_err), 32'd1);
        chk("sat_bad_err_cnt", 32'(err_cnt), STATS ? 32'd1 : 32'd0);
        chk("sat_pkt_hold", 32'(pkt_cnt), STATS ? 32'hF : 32'd0);
        idle();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
